// File: rtl/qe_bus_pkg.sv
// Shared types and helpers for the QL expansion-bus W5300 controller.
// Holds the bus-cycle state enum, sub-address constants and counter sizing.
package qe_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_state_t;

    localparam int OFS_W  = 4;
    localparam int WAIT_W = 4;
    localparam int MAX_CS = 4;

    localparam logic [OFS_W-1:0] OFS_CH0     = 4'h0;
    localparam logic [OFS_W-1:0] DEF_RST_OFS = 4'h4;

    // Width able to hold the value n itself (counters load the full count).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/qe_reset_pulse.sv
// W5300 reset generator: wizrstl low for RST_PULSE clks, then RST_RECOVER clks of busy.
// A trigger at any time restarts the pulse from full length; rst itself acts as a trigger.
module qe_reset_pulse
    import qe_bus_pkg::*;
#(
    parameter int RST_PULSE   = 64,
    parameter int RST_RECOVER = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic wizrstl,
    output logic busy
);

    localparam int PW = cnt_w(RST_PULSE);
    localparam int RW = cnt_w(RST_RECOVER);

    logic [PW-1:0] pulse_cnt;
    logic [RW-1:0] rec_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt <= PW'(RST_PULSE);
            rec_cnt   <= '0;
        end else if (trig) begin
            pulse_cnt <= PW'(RST_PULSE);
            rec_cnt   <= '0;
        end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - 1'b1;
            // Recovery starts on the same edge that releases wizrstl.
            if (pulse_cnt == PW'(1))
                rec_cnt <= RW'(RST_RECOVER);
        end else if (rec_cnt != '0) begin
            rec_cnt <= rec_cnt - 1'b1;
        end
    end

    assign wizrstl = (pulse_cnt == '0);
    assign busy    = !wizrstl || (rec_cnt != '0);

endmodule

// File: rtl/qe_bus_ctrl.sv
// 68008 expansion-bus to W5300 bridge: strobe sync (2 flops with QE_BUS_SYNC_EN, else 1), window
// decode, WAIT_CYCLES wait states, DTACK held until DS/AS release; owns the W5300 reset register.
module qe_bus_ctrl
    import qe_bus_pkg::*;
#(
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-5:0] BASE        = 6'b110010,
    parameter int                NUM_CS      = 2,
    parameter logic [OFS_W-1:0]  RST_OFS     = DEF_RST_OFS,
    parameter int                WAIT_CYCLES = 2,
    parameter int                RST_PULSE   = 64,
    parameter int                RST_RECOVER = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              asl,
    input  logic              dsl,
    input  logic              rdwl,
    output logic              dtackl,
    output logic              dsmcl,
    output logic              dbenl,
    output logic              dbdir,
    output logic [NUM_CS-1:0] cs_l,
    output logic              wizrdl,
    output logic              wizwrl,
    output logic              wizrstl
);

    logic as_s, ds_s, rw_s;

`ifdef QE_BUS_SYNC_EN
    logic [2:0] sync1_q, sync2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= {asl, dsl, rdwl};
            sync2_q <= sync1_q;
        end
    end
    assign {as_s, ds_s, rw_s} = sync2_q;
`else
    logic [2:0] cap_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cap_q <= 3'b111;
        else     cap_q <= {asl, dsl, rdwl};
    end
    assign {as_s, ds_s, rw_s} = cap_q;
`endif

    bus_state_t         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               dir_q;
    logic [OFS_W-1:0]   ofs_q;
    logic               sel_q;
    logic               dtack_q;
    logic               trig_q;
    logic               busy;
    logic               hit;
    logic               strobe_en;

    assign hit = (address[ADDR_W-1:OFS_W] == BASE) && !as_s;

    // sel_q is decided once at cycle start: a cycle begun while the W5300
    // is in reset or recovery never strobes, even if busy ends before DTACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            dir_q    <= 1'b1;
            ofs_q    <= OFS_CH0;
            sel_q    <= 1'b0;
            dtack_q  <= 1'b0;
            dbenl    <= 1'b1;
            dbdir    <= 1'b1;
            trig_q   <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit && !ds_s) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_W'(WAIT_CYCLES);
                        dir_q    <= rw_s;
                        ofs_q    <= address[OFS_W-1:0];
                        sel_q    <= (address[OFS_W-1:0] < OFS_W'(NUM_CS)) && !busy;
                        dbenl    <= 1'b0;
                        dbdir    <= rw_s;
                    end
                end
                WAIT: begin
                    if (as_s) begin
                        state <= IDLE;
                        sel_q <= 1'b0;
                        dbenl <= 1'b1;
                        dbdir <= 1'b1;
                    end else if (wait_cnt == '0) begin
                        state   <= ACK;
                        dtack_q <= 1'b1;
                        trig_q  <= (ofs_q == RST_OFS) && !dir_q;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ACK: begin
                    if (ds_s || as_s) begin
                        state   <= IDLE;
                        dtack_q <= 1'b0;
                        sel_q   <= 1'b0;
                        dbenl   <= 1'b1;
                        dbdir   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    qe_reset_pulse #(
        .RST_PULSE   (RST_PULSE),
        .RST_RECOVER (RST_RECOVER)
    ) u_reset_pulse (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig_q),
        .wizrstl (wizrstl),
        .busy    (busy)
    );

    assign strobe_en = sel_q && !busy;

    always_comb begin
        cs_l = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (strobe_en && (ofs_q == OFS_W'(i)))
                cs_l[i] = 1'b0;
    end

    assign wizrdl = !(strobe_en && dir_q);
    assign wizwrl = !(strobe_en && !dir_q);
    assign dtackl = dtack_q ? 1'b0 : 1'bz;
    assign dsmcl  = (hit && !ds_s) ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_qe_bus_ctrl.sv
// Directed bench for qe_bus_ctrl: decode, wait-state timing, reset register and release.
module tb_qe_bus_ctrl;

`ifdef QE_BUS_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int W = 2;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] address = 10'h000;
    logic       asl = 1'b1;
    logic       dsl = 1'b1;
    logic       rdwl = 1'b1;
    wire        dtackl;
    wire        dsmcl;
    logic       dbenl, dbdir, wizrdl, wizwrl, wizrstl;
    logic [1:0] cs_l;

    // Board-level terminations for the open-drain outputs.
    pullup   (dtackl);
    pulldown (dsmcl);

    qe_bus_ctrl #(
        .ADDR_W      (10),
        .BASE        (6'b110010),
        .NUM_CS      (2),
        .RST_OFS     (4'h4),
        .WAIT_CYCLES (W),
        .RST_PULSE   (P),
        .RST_RECOVER (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .asl     (asl),
        .dsl     (dsl),
        .rdwl    (rdwl),
        .dtackl  (dtackl),
        .dsmcl   (dsmcl),
        .dbenl   (dbenl),
        .dbdir   (dbdir),
        .cs_l    (cs_l),
        .wizrdl  (wizrdl),
        .wizwrl  (wizwrl),
        .wizrstl (wizrstl)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int now   = 0;
    int lowcnt = 0;
    int last_low = -1;

    // Length of the most recent completed wizrstl low run, counted after rst release.
    always @(negedge clk) begin
        if (rst) begin
            lowcnt <= 0;
        end else if (wizrstl === 1'b0) begin
            lowcnt <= lowcnt + 1;
        end else if (lowcnt != 0) begin
            last_low <= lowcnt;
            lowcnt   <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            now++;
        end
    endtask

    task automatic start(input logic [9:0] a, input logic rd);
        address = a;
        rdwl    = rd;
        asl     = 1'b0;
        dsl     = 1'b0;
    endtask

    task automatic release_bus();
        asl  = 1'b1;
        dsl  = 1'b1;
        rdwl = 1'b1;
    endtask

    // Ticks until dtackl is seen low; flags strobe activity seen on the way.
    task automatic wait_ack(input string tag, output int n, output logic strobed);
        n = 0;
        strobed = 1'b0;
        do begin
            tick(1);
            n++;
            if (cs_l !== 2'b11 || wizrdl !== 1'b1 || wizwrl !== 1'b1) strobed = 1'b1;
        end while (dtackl !== 1'b0 && n < 40);
        chk(tag, {31'd0, dtackl}, 32'd0);
    endtask

    int   n, a_t, b_t;
    logic strobed, any_dtack, any_dsmc, any_strobe;

    initial begin
        // Reset state
        tick(3);
        chk("rst_dtackl", {31'd0, dtackl}, 32'd1);
        chk("rst_dsmcl", {31'd0, dsmcl}, 32'd0);
        chk("rst_dbenl_dbdir", {30'd0, dbenl, dbdir}, 32'b11);
        chk("rst_cs_l", {30'd0, cs_l}, 32'b11);
        chk("rst_wiz_rd_wr", {30'd0, wizrdl, wizwrl}, 32'b11);
        chk("rst_wizrstl", {31'd0, wizrstl}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick(20);
        chk("por_pulse_len", last_low, P);

        // Read offset 0: cycle timing and strobes
        start(10'h320, 1'b1);
        tick(S + 1);
        chk("rd0_wait_cs_l", {30'd0, cs_l}, 32'b10);
        chk("rd0_wait_rd_wr", {30'd0, wizrdl, wizwrl}, 32'b01);
        chk("rd0_wait_dben_dir", {30'd0, dbenl, dbdir}, 32'b01);
        chk("rd0_dsmcl", {31'd0, dsmcl}, 32'd1);
        tick(W);
        chk("rd0_no_early_dtack", {31'd0, dtackl}, 32'd1);
        tick(1);
        chk("rd0_dtack_edge", {31'd0, dtackl}, 32'd0);
        chk("rd0_ack_cs_l", {30'd0, cs_l}, 32'b10);
        release_bus();
        tick(S);
        chk("rd0_dtack_hold", {31'd0, dtackl}, 32'd0);
        tick(1);
        chk("rd0_rel_dtackl", {31'd0, dtackl}, 32'd1);
        chk("rd0_rel_cs_l", {30'd0, cs_l}, 32'b11);
        chk("rd0_rel_strobes", {29'd0, wizrdl, dbenl, dbdir}, 32'b111);
        tick(2);

        // Write offset 1
        start(10'h321, 1'b0);
        tick(S + 1);
        chk("wr1_cs_l", {30'd0, cs_l}, 32'b01);
        chk("wr1_rd_wr", {30'd0, wizrdl, wizwrl}, 32'b10);
        chk("wr1_dben_dir", {30'd0, dbenl, dbdir}, 32'b00);
        wait_ack("wr1_ack", n, strobed);
        chk("wr1_ack_latency", n, S + W + 2 - (S + 1));
        chk("wr1_ack_dben", {31'd0, dbenl}, 32'd0);
        release_bus();
        tick(S + 2);

        // Non-matching address
        start(10'h300, 1'b1);
        any_dtack = 1'b0;
        any_dsmc = 1'b0;
        any_strobe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (dtackl !== 1'b1) any_dtack = 1'b1;
            if (dsmcl !== 1'b0) any_dsmc = 1'b1;
            if (cs_l !== 2'b11 || wizrdl !== 1'b1 || wizwrl !== 1'b1 || dbenl !== 1'b1)
                any_strobe = 1'b1;
        end
        chk("miss_dtack", {31'd0, any_dtack}, 32'd0);
        chk("miss_dsmcl", {31'd0, any_dsmc}, 32'd0);
        chk("miss_strobes", {31'd0, any_strobe}, 32'd0);
        release_bus();
        tick(2);

        // Reset register write, then a read inside the recovery window
        start(10'h324, 1'b0);
        wait_ack("rstw_ack", n, strobed);
        chk("rstw_no_strobe", {31'd0, strobed}, 32'd0);
        release_bus();
        tick(1);
        chk("rstw_wizrstl_low", {31'd0, wizrstl}, 32'd0);
        n = 0;
        while (wizrstl === 1'b0 && n < 40) begin
            tick(1);
            n++;
        end
        start(10'h320, 1'b1);
        wait_ack("recov_rd_ack", n, strobed);
        chk("recov_rd_no_cs", {31'd0, strobed}, 32'd0);
        release_bus();
        tick(S + 2);
        chk("rstw_pulse_len", last_low, P);
        tick(10);

        // Retrigger while the pulse is running; back-to-back cycles, asl held low
        start(10'h324, 1'b0);
        a_t = now;
        wait_ack("retrig_a_ack", n, strobed);
        dsl = 1'b1;
        tick(1);
        dsl = 1'b0;
        b_t = now;
        tick(2);
        chk("b2b_dtack_gap", {31'd0, dtackl}, 32'd1);
        wait_ack("retrig_b_ack", n, strobed);
        release_bus();
        n = 0;
        while (wizrstl !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        tick(2);
        chk("retrig_pulse_len", last_low, (b_t - a_t) + P);
        tick(10);

        // Abort: asl released while in WAIT
        start(10'h320, 1'b1);
        tick(S + 1);
        asl = 1'b1;
        any_dtack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (dtackl !== 1'b1) any_dtack = 1'b1;
        end
        chk("abort_no_dtack", {31'd0, any_dtack}, 32'd0);
        chk("abort_cs_l", {30'd0, cs_l}, 32'b11);
        chk("abort_dbenl", {31'd0, dbenl}, 32'd1);
        release_bus();
        tick(2);

        // Read of the reset register: acked, no reset
        start(10'h324, 1'b1);
        wait_ack("rstr_ack", n, strobed);
        release_bus();
        tick(S + 3);
        chk("rstr_no_reset", {31'd0, wizrstl}, 32'd1);

        // Unmapped offset 7: acked, no strobes
        start(10'h327, 1'b1);
        wait_ack("ofs7_ack", n, strobed);
        chk("ofs7_no_strobe", {31'd0, strobed}, 32'd0);
        release_bus();
        tick(S + 2);

        // rst asserted during ACK releases DTACK at once
        start(10'h320, 1'b1);
        wait_ack("rstack_ack", n, strobed);
        #1 rst = 1'b1;
        #1;
        chk("rstack_dtackl", {31'd0, dtackl}, 32'd1);
        chk("rstack_cs_l", {30'd0, cs_l}, 32'b11);
        chk("rstack_wizrstl", {31'd0, wizrstl}, 32'd0);
        release_bus();
        tick(2);
        @(posedge clk);
        #2 rst = 1'b0;
        n = 0;
        while (wizrstl !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        tick(2);
        chk("rstack_pulse_len", last_low, P);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
